// File: rtl/fetch_queue_unit.sv
// Prefetching instruction fetch unit: issues one-cycle-latency imem reads and
// buffers returned words with their PCs in a DEPTH-entry queue for decode.
module fetch_queue_unit #(
    parameter int unsigned         INST_W     = 9,
    parameter int unsigned         PC_W       = 9,
    parameter int unsigned         IMM_W      = 6,
    parameter int unsigned         DEPTH      = 4,
    parameter logic [PC_W-1:0]     RESET_PC   = '0,
    parameter logic [INST_W-1:0]   HALT_WORD  = INST_W'(1),
    parameter bit                  SIGNED_IMM = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              init,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              br_abs,
    input  logic [PC_W-1:0]   br_target,
    input  logic              br_rel,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [IMM_W-1:0]  br_imm,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic              stop_fetch_q, stop_fetch_d;
    logic              halted_q, halted_d;

    logic              redirect_c;
    logic [PC_W-1:0]   imm_ext_c;
    logic [PC_W-1:0]   target_c;
    logic [OCC_W-1:0]  occ_c;
    logic              halt_resp_c;
    logic              req_c;
    logic              push_c;
    logic              pop_c;
    logic              valid_c;

    // Redirect decode with init > br_abs > br_rel priority
    always_comb begin
        redirect_c = init | br_abs | br_rel;
        if (SIGNED_IMM) begin
            imm_ext_c = PC_W'($signed(br_imm));
        end else begin
            imm_ext_c = PC_W'(br_imm);
        end
        if (init) begin
            target_c = start_addr;
        end else if (br_abs) begin
            target_c = br_target;
        end else begin
            target_c = br_pc + imm_ext_c;
        end
    end

    // A HALT word arriving this cycle already blocks the next request, so no
    // address past the HALT is ever fetched.
    always_comb begin
        occ_c       = OCC_W'(count_q) + OCC_W'(inflight_q);
        halt_resp_c = inflight_q & (imem_data == HALT_WORD);
        req_c       = rst_n & en & ~stop_fetch_q & ~halt_resp_c & ~redirect_c
                      & (occ_c < OCC_W'(DEPTH));
        push_c      = inflight_q & ~redirect_c;
        valid_c     = rst_n & (count_q != '0);
        pop_c       = valid_c & inst_ready;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inst_mem_d    = inst_mem_q;
        pc_mem_d      = pc_mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        inflight_d    = req_c;
        inflight_pc_d = inflight_pc_q;
        stop_fetch_d  = stop_fetch_q;
        halted_d      = halted_q;

        if (req_c) begin
            fetch_pc_d    = fetch_pc_q + PC_W'(1);
            inflight_pc_d = fetch_pc_q;
        end

        if (push_c) begin
            inst_mem_d[tail_q] = imem_data;
            pc_mem_d[tail_q]   = inflight_pc_q;
            tail_d             = tail_q + PTR_W'(1);
            if (imem_data == HALT_WORD) begin
                stop_fetch_d = 1'b1;
            end
        end

        if (pop_c) begin
            head_d = head_q + PTR_W'(1);
            if (inst_mem_q[head_q] == HALT_WORD) begin
                halted_d = 1'b1;
            end
        end

        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Flush after any handshake in the same cycle has consumed its word
        if (redirect_c) begin
            fetch_pc_d   = target_c;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            stop_fetch_d = 1'b0;
            halted_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            stop_fetch_q  <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            stop_fetch_q  <= stop_fetch_d;
            halted_q      <= halted_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    always_comb begin
        imem_req   = req_c;
        imem_addr  = req_c ? fetch_pc_q : '0;
        inst_valid = valid_c;
        inst       = valid_c ? inst_mem_q[head_q] : '0;
        inst_pc    = valid_c ? pc_mem_q[head_q] : '0;
        halted     = rst_n & halted_q;
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; two instances differ only in SIGNED_IMM.
module tb_fetch_queue_unit;

    logic       clk = 1'b0;
    logic       rst_n, en, init, br_abs, br_rel, inst_ready;
    logic [8:0] start_addr, br_target, br_pc;
    logic [5:0] br_imm;

    logic       req_a, valid_a, halted_a, req_b, valid_b, halted_b;
    logic [8:0] addr_a, inst_a, pc_a, addr_b, inst_b, pc_b;
    logic [8:0] data_a, data_b;

    logic halt_en = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(.SIGNED_IMM(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .init(init), .start_addr(start_addr),
        .br_abs(br_abs), .br_target(br_target), .br_rel(br_rel), .br_pc(br_pc),
        .br_imm(br_imm), .imem_req(req_a), .imem_addr(addr_a), .imem_data(data_a),
        .inst_valid(valid_a), .inst_ready(inst_ready), .inst(inst_a),
        .inst_pc(pc_a), .halted(halted_a)
    );

    fetch_queue_unit #(.SIGNED_IMM(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .init(init), .start_addr(start_addr),
        .br_abs(br_abs), .br_target(br_target), .br_rel(br_rel), .br_pc(br_pc),
        .br_imm(br_imm), .imem_req(req_b), .imem_addr(addr_b), .imem_data(data_b),
        .inst_valid(valid_b), .inst_ready(inst_ready), .inst(inst_b),
        .inst_pc(pc_b), .halted(halted_b)
    );

    // mem[a] = a, except address 1 (whose value would be HALT) and an optional HALT at 21
    function automatic logic [8:0] mem_f(input logic [8:0] a);
        if (halt_en && a == 9'd21) return 9'd1;
        if (a == 9'd1) return 9'h1FE;
        return a;
    endfunction

    always @(posedge clk) begin
        data_a <= mem_f(addr_a);
        data_b <= mem_f(addr_b);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0; en = 1'b0; init = 1'b0; br_abs = 1'b0; br_rel = 1'b0;
        inst_ready = 1'b0; start_addr = '0; br_target = '0; br_pc = '0; br_imm = '0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; inst_ready = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (req_a !== 1'b0 || addr_a !== 9'd0) begin errors++;
            $display("FAIL reset_req got req=%0b addr=%0d exp 0/0", req_a, addr_a); end
        checks++; if (valid_a !== 1'b0 || inst_a !== 9'd0 || pc_a !== 9'd0) begin errors++;
            $display("FAIL reset_inst got v=%0b i=%0d pc=%0d exp 0/0/0", valid_a, inst_a, pc_a); end
        checks++; if (halted_a !== 1'b0) begin errors++;
            $display("FAIL reset_halted got %0b exp 0", halted_a); end
    endtask

    task automatic test_stream();
        logic [8:0] exp_pc;
        do_reset();
        for (int c = 0; c < 516; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1; #1;
            checks++; if (req_a !== 1'b1 || addr_a !== 9'(c)) begin errors++;
                $display("FAIL stream_addr c=%0d got req=%0b addr=%0d exp 1/%0d", c, req_a, addr_a, 9'(c)); end
            if (c >= 2) begin
                exp_pc = 9'(c - 2);
                checks++; if (valid_a !== 1'b1 || pc_a !== exp_pc || inst_a !== mem_f(exp_pc)) begin errors++;
                    $display("FAIL stream_inst c=%0d got v=%0b pc=%0d i=%0d exp 1/%0d/%0d",
                             c, valid_a, pc_a, inst_a, exp_pc, mem_f(exp_pc)); end
            end else begin
                checks++; if (valid_a !== 1'b0) begin errors++;
                    $display("FAIL stream_startup c=%0d got valid=%0b exp 0", c, valid_a); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b0; #1;
            if (req_a === 1'b1) nreq++;
        end
        checks++; if (nreq != 4) begin errors++;
            $display("FAIL bp_req_count got %0d exp 4", nreq); end
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'd0) begin errors++;
            $display("FAIL bp_hold got v=%0b pc=%0d exp 1/0", valid_a, pc_a); end
        for (int c = 10; c < 15; c++) begin
            cyc(); inst_ready = 1'b1; #1;
            checks++; if (valid_a !== 1'b1 || pc_a !== 9'(c - 10)) begin errors++;
                $display("FAIL bp_drain c=%0d got v=%0b pc=%0d exp 1/%0d", c, valid_a, pc_a, c - 10); end
        end
    endtask

    task automatic test_br_rel();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b0; #1;
        end
        cyc(); br_rel = 1'b1; br_pc = 9'd20; br_imm = 6'b111110; #1;
        checks++; if (req_a !== 1'b0 || req_b !== 1'b0) begin errors++;
            $display("FAIL brrel_no_req got a=%0b b=%0b exp 0/0", req_a, req_b); end
        cyc(); br_rel = 1'b0; inst_ready = 1'b1; #1;
        checks++; if (req_a !== 1'b1 || addr_a !== 9'd82 || valid_a !== 1'b0) begin errors++;
            $display("FAIL brrel_zext_req got req=%0b addr=%0d v=%0b exp 1/82/0", req_a, addr_a, valid_a); end
        checks++; if (req_b !== 1'b1 || addr_b !== 9'd18 || valid_b !== 1'b0) begin errors++;
            $display("FAIL brrel_sext_req got req=%0b addr=%0d v=%0b exp 1/18/0", req_b, addr_b, valid_b); end
        cyc(); #1;
        checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin errors++;
            $display("FAIL brrel_gap got a=%0b b=%0b exp 0/0", valid_a, valid_b); end
        cyc(); #1;
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'd82 || inst_a !== 9'd82) begin errors++;
            $display("FAIL brrel_zext_inst got v=%0b pc=%0d i=%0d exp 1/82/82", valid_a, pc_a, inst_a); end
        checks++; if (valid_b !== 1'b1 || pc_b !== 9'd18 || inst_b !== 9'd18) begin errors++;
            $display("FAIL brrel_sext_inst got v=%0b pc=%0d i=%0d exp 1/18/18", valid_b, pc_b, inst_b); end
    endtask

    task automatic test_init_priority();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1; #1;
        end
        cyc(); init = 1'b1; start_addr = 9'd100; br_abs = 1'b1; br_target = 9'd7; #1;
        checks++; if (req_a !== 1'b0 || valid_a !== 1'b1 || pc_a !== 9'd1) begin errors++;
            $display("FAIL init_cycle got req=%0b v=%0b pc=%0d exp 0/1/1", req_a, valid_a, pc_a); end
        cyc(); init = 1'b0; br_abs = 1'b0; #1;
        checks++; if (req_a !== 1'b1 || addr_a !== 9'd100 || valid_a !== 1'b0) begin errors++;
            $display("FAIL init_req got req=%0b addr=%0d v=%0b exp 1/100/0", req_a, addr_a, valid_a); end
        cyc(); #1;
        checks++; if (valid_a !== 1'b0) begin errors++;
            $display("FAIL init_stale got valid=%0b pc=%0d exp 0", valid_a, pc_a); end
        cyc(); #1;
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'd100) begin errors++;
            $display("FAIL init_first got v=%0b pc=%0d exp 1/100", valid_a, pc_a); end
        cyc(); #1;
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'd101) begin errors++;
            $display("FAIL init_second got v=%0b pc=%0d exp 1/101", valid_a, pc_a); end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        do_reset();
        for (int c = 0; c < 27; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1; #1;
            if (c == 21) begin
                checks++; if (req_a !== 1'b1 || addr_a !== 9'd21) begin errors++;
                    $display("FAIL halt_fetch21 got req=%0b addr=%0d exp 1/21", req_a, addr_a); end
            end
            if (c >= 22) begin
                checks++; if (req_a !== 1'b0) begin errors++;
                    $display("FAIL halt_no_req c=%0d got req=1 addr=%0d exp req=0", c, addr_a); end
            end
            if (c == 23) begin
                checks++; if (valid_a !== 1'b1 || pc_a !== 9'd21 || inst_a !== 9'd1 || halted_a !== 1'b0) begin errors++;
                    $display("FAIL halt_deliver got v=%0b pc=%0d i=%0d h=%0b exp 1/21/1/0",
                             valid_a, pc_a, inst_a, halted_a); end
            end
            if (c == 24) begin
                checks++; if (halted_a !== 1'b1 || valid_a !== 1'b0) begin errors++;
                    $display("FAIL halt_set got h=%0b v=%0b exp 1/0", halted_a, valid_a); end
            end
        end
        cyc(); init = 1'b1; start_addr = 9'd30; #1;
        checks++; if (halted_a !== 1'b1) begin errors++;
            $display("FAIL halt_hold got %0b exp 1", halted_a); end
        cyc(); init = 1'b0; #1;
        checks++; if (halted_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 9'd30) begin errors++;
            $display("FAIL halt_clear got h=%0b req=%0b addr=%0d exp 0/1/30", halted_a, req_a, addr_a); end
        halt_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(); rst_n = 1'b1; en = 1'b1; inst_ready = 1'b0; #1;
        end
        cyc(); rst_n = 1'b0; init = 1'b1; start_addr = 9'd50; inst_ready = 1'b1; #1;
        checks++; if ({req_a, addr_a, valid_a, inst_a, pc_a, halted_a} !== '0) begin errors++;
            $display("FAIL rstmid_outputs got req=%0b addr=%0d v=%0b i=%0d pc=%0d h=%0b exp all 0",
                     req_a, addr_a, valid_a, inst_a, pc_a, halted_a); end
        cyc(); init = 1'b0; #1;
        checks++; if (valid_a !== 1'b0 || req_a !== 1'b0) begin errors++;
            $display("FAIL rstmid_hold got v=%0b req=%0b exp 0/0", valid_a, req_a); end
        cyc(); rst_n = 1'b1; #1;
        checks++; if (req_a !== 1'b1 || addr_a !== 9'd0 || valid_a !== 1'b0) begin errors++;
            $display("FAIL rstmid_restart got req=%0b addr=%0d v=%0b exp 1/0/0", req_a, addr_a, valid_a); end
        cyc(); cyc(); #1;
        checks++; if (valid_a !== 1'b1 || pc_a !== 9'd0) begin errors++;
            $display("FAIL rstmid_first got v=%0b pc=%0d exp 1/0", valid_a, pc_a); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; init = 1'b0; br_abs = 1'b0; br_rel = 1'b0;
        inst_ready = 1'b0; start_addr = '0; br_target = '0; br_pc = '0; br_imm = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_br_rel();
        test_init_priority();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised prefetching instruction fetch unit for the cirno core, the successor to the single-register fetch stage. It keeps a program counter and issues requests to a synchronous instruction memory with a fixed one-cycle read latency. Returned instructions go into a DEPTH-entry queue with their PCs, and decode drains it through a valid/ready handshake. Redirects (init, absolute branch, relative branch) flush the queue and any in-flight request, and fetch stops once a HALT word has been fetched.

## Interface
Parameters:
- INST_W, 9: instruction width
- PC_W, 9: PC and instruction-memory address width
- IMM_W, 6: relative-branch immediate width
- DEPTH, 4: queue entries; power of two, at least 2
- RESET_PC, 0: PC loaded by reset
- HALT_WORD, 9'b000000001: encoding that stops fetch
- SIGNED_IMM, 0: 1 sign-extends br_imm, 0 zero-extends it (legacy)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  fetch enable; gates new requests only
- init  in  1  redirect to start_addr
- start_addr  in  PC_W  init target
- br_abs  in  1  absolute branch redirect
- br_target  in  PC_W  absolute target
- br_rel  in  1  relative branch redirect
- br_pc  in  PC_W  PC of the branching instruction (taken from inst_pc)
- br_imm  in  IMM_W  relative offset
- imem_req  out  1  read request this cycle
- imem_addr  out  PC_W  read address; 0 when imem_req=0
- imem_data  in  INST_W  read data; valid the cycle after imem_req
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts the head
- inst  out  INST_W  head instruction; 0 when inst_valid=0
- inst_pc  out  PC_W  head PC; 0 when inst_valid=0
- halted  out  1  HALT_WORD has been handed to decode

## Operation
- State: fetch_pc, DEPTH-entry queue {inst, pc} with head/tail/count, inflight flag and inflight_pc, stop_fetch, halted.
- Redirect priority: rst_n=0, then init, then br_abs, then br_rel. The redirect target is:
  - init: start_addr
  - br_abs: br_target
  - br_rel: (br_pc + ext(br_imm)) mod 2^PC_W, with ext chosen by SIGNED_IMM.
- On any redirect:
  - fetch_pc is set to the target.
  - The queue is emptied and the inflight response is discarded.
  - stop_fetch and halted are cleared.
  - imem_req is 0 in that cycle.
- Request rule: imem_req = rst_n & en & !stop_fetch & !redirect & (count + inflight < DEPTH).
  - On a request, imem_addr = fetch_pc and fetch_pc increments mod 2^PC_W.
  - inflight is set with inflight_pc = fetch_pc.
- Response: in the cycle after a request, imem_data is written to the tail with inflight_pc, unless a redirect occurs that cycle.
  - If imem_data == HALT_WORD, stop_fetch is set; the HALT word is still enqueued.
- Dequeue: when inst_valid & inst_ready, the head is popped.
  - If the popped word is HALT_WORD, halted is set from the next cycle.
  - A handshake in a redirect cycle completes (the word is consumed), then the flush applies.
- A simultaneous enqueue and dequeue leaves count unchanged. The request rule makes overflow impossible.
- With en=0, the inflight response is still accepted and the queue still drains.
- A HALT word already in the queue behind an older branch is discarded by that branch's redirect, which also clears stop_fetch.

## Timing
- Reset (rst_n=0 at an edge): fetch_pc=RESET_PC, queue empty, inflight=0, stop_fetch=0, halted=0. All outputs are 0 during reset and in the following cycle until state updates.
- First cycle with rst_n=1 and en=1 (cycle 0): imem_req=1, imem_addr=RESET_PC. Data arrives in cycle 1, and inst_valid=1 with inst_pc=RESET_PC in cycle 2.
- Steady state: one request per cycle, so with inst_ready held high decode gets one instruction per cycle.
- Redirect in cycle R: no request in R; request to the target in R+1; target instruction valid in R+3.
- Queue full (count + inflight = DEPTH): requests stop. They resume in the cycle after the first pop.
- Reset asserted mid-operation overrides everything, including a concurrent redirect or response.

## Test plan
- Reset, then en=1, inst_ready=1, memory holds mem[a]=a -> imem_addr runs 0,1,2,…; inst_pc/inst = 0,1,2,… starting cycle 2; imem_addr wraps 511 -> 0.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, inst_valid stays 1 on PC 0; after ready=1, PCs 0..3 then 4 with no gap or duplicate.
- br_rel with br_pc=20, br_imm=6'b111110:
  - SIGNED_IMM=0 -> next valid inst_pc=82.
  - SIGNED_IMM=1 -> next valid inst_pc=18.
  - In both cases the queued entries and the inflight response are dropped.
- init with start_addr=100 in the same cycle as br_abs with br_target=7 and an inflight response -> fetch resumes at 100; the stale word is never delivered; first valid in R+3.
- HALT_WORD at address 21 -> no request above address 21; PC 21 is delivered; halted=1 the cycle after its handshake; init clears halted.
- rst_n=0 while queue full and request inflight -> all outputs 0; after release, fetch restarts at RESET_PC.
